// File: rtl/randseq_token_exec.sv
// randseq_token_exec: parses "op operand done" token sentences into a signed accumulator, one result per sentence.
// Define RANDSEQ_TOKEN_EXEC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module randseq_token_exec #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [2:0]       tok_code,
    input  logic             clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_acc,
    output logic             res_err,
    output logic             res_ovf,
    output logic [CNT_W-1:0] seq_cnt
);
    typedef enum logic [1:0] {S_OP, S_OPND, S_DONE, S_OUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             op_sub;
    logic [1:0]       opnd;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] new_acc;
    logic             tok_ok;

    assign tok_ready = (state != S_OUT);
    // One extra bit holds the true signed sum; overflow when the top two bits disagree.
    assign sum = op_sub ? {acc[ACC_W-1], acc} - (ACC_W+1)'(opnd)
                        : {acc[ACC_W-1], acc} + (ACC_W+1)'(opnd);
    assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef RANDSEQ_TOKEN_EXEC_SATURATE_EN
    assign new_acc = !ovf ? sum[ACC_W-1:0] :
                     sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign new_acc = sum[ACC_W-1:0];
`endif
    assign tok_ok = (state == S_OP)   ? (tok_code <= 3'd1) :
                    (state == S_OPND) ? (tok_code >= 3'd2 && tok_code <= 3'd4) :
                                        (tok_code == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OP;
            acc       <= '0;
            op_sub    <= 1'b0;
            opnd      <= '0;
            res_valid <= 1'b0;
            res_acc   <= '0;
            res_err   <= 1'b0;
            res_ovf   <= 1'b0;
            seq_cnt   <= '0;
        end else begin
            if (clr)
                acc <= '0;
            if (state == S_OUT) begin
                if (res_ready) begin
                    state     <= S_OP;
                    res_valid <= 1'b0;
                    if (!res_err)
                        seq_cnt <= seq_cnt + 1'b1;
                end
            end else if (tok_valid) begin
                if (!tok_ok) begin
                    state     <= S_OUT;
                    res_valid <= 1'b1;
                    res_acc   <= acc;
                    res_err   <= 1'b1;
                    res_ovf   <= 1'b0;
                end else if (state == S_OP) begin
                    op_sub <= tok_code[0];
                    state  <= S_OPND;
                end else if (state == S_OPND) begin
                    // ONE/TWO/THREE are codes 2/3/4, so the low bits minus one give 1/2/3.
                    opnd  <= tok_code[1:0] - 2'd1;
                    state <= S_DONE;
                end else begin
                    state     <= S_OUT;
                    res_valid <= 1'b1;
                    res_err   <= 1'b0;
                    res_ovf   <= !clr && ovf;
                    res_acc   <= clr ? '0 : new_acc;
                    if (!clr)
                        acc <= new_acc;
                end
            end
        end
    end
endmodule

// File: tb/tb_randseq_token_exec.sv
// tb_randseq_token_exec: directed plus randomized checks against a sentence-level integer model.
module tb_randseq_token_exec;
    localparam int W  = 8;
    localparam int CW = 16;
    localparam int MX = (1 << (W-1)) - 1;
    localparam int MN = -(1 << (W-1));

    logic          clk = 0, rst_n = 0, tok_valid = 0, clr = 0, res_ready = 0;
    logic [2:0]    tok_code = 0;
    logic          tok_ready, res_valid, res_err, res_ovf;
    logic [W-1:0]  res_acc;
    logic [CW-1:0] seq_cnt;

    randseq_token_exec #(.ACC_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_code(tok_code), .clr(clr), .res_valid(res_valid), .res_ready(res_ready),
        .res_acc(res_acc), .res_err(res_err), .res_ovf(res_ovf), .seq_cnt(seq_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_acc, m_racc, m_pos, m_val, m_cnt;
    bit m_sub, m_pend, m_err, m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fold(input int t);
`ifdef RANDSEQ_TOKEN_EXEC_SATURATE_EN
        return t > MX ? MX : t < MN ? MN : t;
`else
        int u = t & ((1 << W) - 1);
        return u > MX ? u - (1 << W) : u;
`endif
    endfunction

    function automatic int racc_now();
        return int'($signed(res_acc));
    endfunction

    task automatic model_reset();
        m_acc = 0; m_racc = 0; m_pos = 0; m_val = 0; m_cnt = 0;
        m_sub = 0; m_pend = 0; m_err = 0; m_ovf = 0;
    endtask

    // Sentence-level model: position in "op operand done", pending result, integer accumulator.
    task automatic model_edge();
        int  c, t;
        bit  legal;
        c = int'(tok_code);
        if (m_pend) begin
            if (res_ready) begin
                m_pend = 0;
                if (!m_err) m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end else if (tok_valid) begin
            legal = m_pos == 0 ? c <= 1 : m_pos == 1 ? (c >= 2 && c <= 4) : c == 5;
            if (!legal) begin
                m_racc = m_acc; m_err = 1; m_ovf = 0; m_pend = 1; m_pos = 0;
            end else if (m_pos == 0) begin
                m_sub = (c == 1); m_pos = 1;
            end else if (m_pos == 1) begin
                m_val = c - 1; m_pos = 2;
            end else begin
                t = m_sub ? m_acc - m_val : m_acc + m_val;
                m_err = 0; m_pend = 1; m_pos = 0;
                if (clr) begin
                    m_acc = 0; m_racc = 0; m_ovf = 0;
                end else begin
                    m_ovf = (t > MX) || (t < MN);
                    m_acc = fold(t); m_racc = m_acc;
                end
            end
        end
        if (clr) m_acc = 0;
    endtask

    task automatic compare();
        check("tok_ready", int'(tok_ready), int'(!m_pend));
        check("res_valid", int'(res_valid), int'(m_pend));
        check("seq_cnt", int'(seq_cnt), m_cnt);
        if (m_pend) begin
            check("res_acc", racc_now(), m_racc);
            check("res_err", int'(res_err), int'(m_err));
            check("res_ovf", int'(res_ovf), int'(m_ovf));
        end
    endtask

    task automatic step(input int v, input int c, input int rr, input int cl);
        tok_valid = v[0]; tok_code = 3'(c); res_ready = rr[0]; clr = cl[0];
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic sentence(input int sub, input int val);
        step(1, sub, 1, 0);
        step(1, val + 1, 1, 0);
        step(1, 5, 1, 0);
        step(0, 0, 1, 0);
    endtask

    initial begin
        int c;
        model_reset();
        #12;
        check("rst_tok_ready", int'(tok_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_acc", racc_now(), 0);
        check("rst_seq_cnt", int'(seq_cnt), 0);
        rst_n = 1;
        // basic ADD TWO
        step(1, 0, 1, 0); step(1, 3, 1, 0); step(1, 5, 1, 0);
        check("basic_acc", racc_now(), 2);
        check("basic_err", int'(res_err), 0);
        step(0, 0, 1, 0);
        check("basic_cnt", int'(seq_cnt), 1);
        // SUB THREE to negative
        step(1, 1, 1, 0); step(1, 4, 1, 0); step(1, 5, 1, 0);
        check("sub_acc", racc_now(), -1);
        step(0, 0, 1, 0);
        check("sub_cnt", int'(seq_cnt), 2);
        // grammar error and resync from acc=2
        step(0, 0, 0, 1);
        sentence(0, 2);
        step(1, 2, 1, 0);
        check("err_flag", int'(res_err), 1);
        check("err_acc", racc_now(), 2);
        step(0, 0, 1, 0);
        check("err_cnt", int'(seq_cnt), 3);
        sentence(0, 1);
        check("resync_cnt", int'(seq_cnt), 4);
        // overflow from 126
        step(0, 0, 0, 1);
        for (int i = 0; i < 42; i++) sentence(0, 3);
        step(1, 0, 1, 0); step(1, 4, 1, 0); step(1, 5, 0, 0);
`ifdef RANDSEQ_TOKEN_EXEC_SATURATE_EN
        check("ovf_acc", racc_now(), 127);
`else
        check("ovf_acc", racc_now(), -127);
`endif
        check("ovf_flag", int'(res_ovf), 1);
        // result backpressure with tokens offered
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            check("bp_tok_ready", int'(tok_ready), 0);
        end
        step(1, 0, 1, 0);
        check("bp_release", int'(tok_ready), 1);
        // clr coincident with DONE
        sentence(0, 1);
        step(1, 0, 1, 0); step(1, 2, 1, 0); step(1, 5, 1, 1);
        check("clr_done_acc", racc_now(), 0);
        check("clr_done_ovf", int'(res_ovf), 0);
        step(0, 0, 1, 0);
        // reset mid-sentence
        step(1, 0, 1, 0); step(1, 2, 1, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("mid_rst_ready", int'(tok_ready), 1);
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_cnt", int'(seq_cnt), 0);
        compare();
        #2 rst_n = 1;
        step(1, 1, 1, 0); step(1, 3, 1, 0); step(1, 5, 1, 0);
        check("post_rst_acc", racc_now(), -2);
        step(0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 7);
            else c = m_pos == 0 ? $urandom_range(0, 1) : m_pos == 1 ? $urandom_range(2, 4) : 5;
            step(int'($urandom_range(0, 3) != 0), c, int'($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 31) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
